// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings, field positions and helpers for the RAW hazard scoreboard.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    RD_RD = 2'b00,
    RD_RT = 2'b01,
    RD_RS = 2'b10,
    RD_R7 = 2'b11
  } regdst_e;

  localparam int unsigned RS_HI = 10;
  localparam int unsigned RS_LO = 8;
  localparam int unsigned RT_HI = 7;
  localparam int unsigned RT_LO = 5;
  localparam int unsigned RD_HI = 4;
  localparam int unsigned RD_LO = 2;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [2:0]  LINK_REG  = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [2:0] rgn;
  } sb_entry_t;

  function automatic logic [2:0] dest_decode(input logic [15:0] instr, input logic [1:0] regdst);
    logic [2:0] dest;
    dest = LINK_REG;
    case (regdst_e'(regdst))
      RD_RD:   dest = instr[RD_HI:RD_LO];
      RD_RT:   dest = instr[RT_HI:RT_LO];
      RD_RS:   dest = instr[RS_HI:RS_LO];
      default: dest = LINK_REG;
    endcase
    return dest;
  endfunction

  function automatic logic entry_hit(input sb_entry_t e, input logic [2:0] r);
    return e.valid && (e.rgn == r);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: a {valid, reg} register that holds while en is low.
module hazard_sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  sb_entry_t d,
  output sb_entry_t q
);

  sb_entry_t entry_d, entry_q;

  always_comb begin
    entry_d = entry_q;
    if (en) entry_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

  assign q = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector: a 3-deep destination scoreboard (EX/MEM/WB)
// compared against the decode sources, producing bubble stall and PC/IF-ID enables.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [15:0]      instr_id,
  input  logic             ReadingRs_id,
  input  logic             ReadingRt_id,
  input  logic             RegWrite_id,
  input  logic [1:0]       RegDst_id,
  input  logic             flush,
  output logic             stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic [CNT_W-1:0] stall_count
);

  sb_entry_t ex_d, ex_q, mem_q, wb_q;
  logic [2:0] rs, rt;
  logic hit_rs, hit_rt;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;
  logic unused_instr_bits;

  assign rs = instr_id[RS_HI:RS_LO];
  assign rt = instr_id[RT_HI:RT_LO];
  assign unused_instr_bits = ^{instr_id[15:11], instr_id[1:0]};

  always_comb begin
    hit_rs = ReadingRs_id && (entry_hit(ex_q, rs) || entry_hit(mem_q, rs) ||
                              ((WB_BYPASS == 0) && entry_hit(wb_q, rs)));
    hit_rt = ReadingRt_id && (entry_hit(ex_q, rt) || entry_hit(mem_q, rt) ||
                              ((WB_BYPASS == 0) && entry_hit(wb_q, rt)));
    stall   = (hit_rs || hit_rt) && !flush;
    pc_en   = !stall;
    ifid_en = !stall;
  end

  // A stalled or squashed decode instruction enters EX as a write-disabled bubble.
  always_comb begin
    ex_d = '0;
    if (!stall && !flush) begin
      ex_d.valid = RegWrite_id;
      ex_d.rgn   = dest_decode(instr_id, RegDst_id);
    end
  end

  hazard_sb_entry u_ex  (.clk(clk), .rst(rst), .en(en), .d(ex_d),  .q(ex_q));
  hazard_sb_entry u_mem (.clk(clk), .rst(rst), .en(en), .d(ex_q),  .q(mem_q));
  hazard_sb_entry u_wb  (.clk(clk), .rst(rst), .en(en), .d(mem_q), .q(wb_q));

  always_comb begin
    stall_count_d = stall_count_q;
    if (en && stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the hazard scoreboard with WB bypass on/off and a narrow counter.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [15:0] instr_id;
  logic        ReadingRs_id, ReadingRt_id, RegWrite_id;
  logic [1:0]  RegDst_id;

  logic        stall_b, pc_en_b, ifid_en_b;
  logic [15:0] cnt_b;
  logic        stall_n, pc_en_n, ifid_en_n;
  logic [15:0] cnt_n;
  logic        stall_s, pc_en_s, ifid_en_s;
  logic [1:0]  cnt_s;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(16)) u_byp (
    .clk(clk), .rst(rst), .en(en), .instr_id(instr_id),
    .ReadingRs_id(ReadingRs_id), .ReadingRt_id(ReadingRt_id),
    .RegWrite_id(RegWrite_id), .RegDst_id(RegDst_id), .flush(flush),
    .stall(stall_b), .pc_en(pc_en_b), .ifid_en(ifid_en_b), .stall_count(cnt_b)
  );

  hazard_scoreboard #(.WB_BYPASS(0), .CNT_W(16)) u_nob (
    .clk(clk), .rst(rst), .en(en), .instr_id(instr_id),
    .ReadingRs_id(ReadingRs_id), .ReadingRt_id(ReadingRt_id),
    .RegWrite_id(RegWrite_id), .RegDst_id(RegDst_id), .flush(flush),
    .stall(stall_n), .pc_en(pc_en_n), .ifid_en(ifid_en_n), .stall_count(cnt_n)
  );

  hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .instr_id(instr_id),
    .ReadingRs_id(ReadingRs_id), .ReadingRt_id(ReadingRt_id),
    .RegWrite_id(RegWrite_id), .RegDst_id(RegDst_id), .flush(flush),
    .stall(stall_s), .pc_en(pc_en_s), .ifid_en(ifid_en_s), .stall_count(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ins, input logic rs_rd, input logic rt_rd,
                       input logic wr, input logic [1:0] dst);
    instr_id     = ins;
    ReadingRs_id = rs_rd;
    ReadingRt_id = rt_rd;
    RegWrite_id  = wr;
    RegDst_id    = dst;
    #1;
  endtask

  task automatic idle();
    drive(16'h0800, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_stall",   32'(stall_b),   32'd0);
    check("rst_pc_en",   32'(pc_en_b),   32'd1);
    check("rst_ifid_en", 32'(ifid_en_b), 32'd1);
    check("rst_count",   32'(cnt_b),     32'd0);
    check("rst_count_n", 32'(cnt_n),     32'd0);

    // Producer writes R3 (Rd via RegDst=00), reader uses Rs=3
    drive(16'hD8CC, 1'b0, 1'b0, 1'b1, 2'b00);
    check("prod_no_stall", 32'(stall_b), 32'd0);
    tick();
    drive(16'h0300, 1'b1, 1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("byp_stall_%0d", k), 32'(stall_b), (k < 2) ? 32'd1 : 32'd0);
      check($sformatf("byp_pc_en_%0d", k), 32'(pc_en_b), (k < 2) ? 32'd0 : 32'd1);
      check($sformatf("nob_stall_%0d", k), 32'(stall_n), (k < 3) ? 32'd1 : 32'd0);
      check($sformatf("nob_ifid_%0d",  k), 32'(ifid_en_n), (k < 3) ? 32'd0 : 32'd1);
      tick();
    end
    check("byp_count_2", 32'(cnt_b), 32'd2);
    check("nob_count_3", 32'(cnt_n), 32'd3);
    check("sat_count_2", 32'(cnt_s), 32'd2);

    // Second hazard pushes the 2-bit counter into saturation
    drive(16'hD8CC, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    drive(16'h0300, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    check("sat_hold_ones", 32'(cnt_s), 32'd3);
    check("byp_count_4",   32'(cnt_b), 32'd4);
    idle();
    tick();

    // R5 producer, one independent instruction, then Rt=5 reader
    do_reset();
    drive(16'h00A0, 1'b0, 1'b0, 1'b1, 2'b01);
    tick();
    idle();
    check("indep_no_stall", 32'(stall_b), 32'd0);
    tick();
    drive(16'h00A0, 1'b0, 1'b1, 1'b0, 2'b00);
    check("rt_gap_byp_s0", 32'(stall_b), 32'd1);
    check("rt_gap_nob_s0", 32'(stall_n), 32'd1);
    tick();
    check("rt_gap_byp_s1", 32'(stall_b), 32'd0);
    check("rt_gap_nob_s1", 32'(stall_n), 32'd1);
    tick();
    check("rt_gap_nob_s2", 32'(stall_n), 32'd0);
    check("rt_gap_count",  32'(cnt_b),   32'd1);

    // Flush over a live hazard squashes the reader's own R6 write
    do_reset();
    drive(16'hD8CC, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    flush = 1'b1;
    drive(16'h0318, 1'b1, 1'b0, 1'b1, 2'b00);
    check("flush_stall", 32'(stall_b), 32'd0);
    check("flush_pc_en", 32'(pc_en_b), 32'd1);
    tick();
    flush = 1'b0;
    drive(16'h0600, 1'b1, 1'b0, 1'b0, 2'b00);
    check("flush_bubble", 32'(stall_b), 32'd0);
    check("flush_count",  32'(cnt_b),   32'd0);
    idle();
    tick();

    // en=0 freezes scoreboard and counter mid-stall
    do_reset();
    drive(16'hD8CC, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    drive(16'h0300, 1'b1, 1'b0, 1'b0, 2'b00);
    check("frz_stall_pre", 32'(stall_b), 32'd1);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("frz_stall_%0d", k), 32'(stall_b), 32'd1);
      check($sformatf("frz_count_%0d", k), 32'(cnt_b),   32'd0);
    end
    en = 1'b1;
    #1;
    tick();
    check("frz_resume_stall", 32'(stall_b), 32'd1);
    check("frz_resume_count", 32'(cnt_b),   32'd1);
    tick();
    check("frz_done_stall", 32'(stall_b), 32'd0);
    check("frz_done_count", 32'(cnt_b),   32'd2);
    idle();
    tick();

    // rst in the first stall cycle
    do_reset();
    drive(16'hD8CC, 1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    drive(16'h0300, 1'b1, 1'b0, 1'b0, 2'b00);
    check("rs_mid_stall", 32'(stall_b), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rs_after_stall", 32'(stall_b), 32'd0);
    check("rs_after_pc_en", 32'(pc_en_b), 32'd1);
    check("rs_after_count", 32'(cnt_b),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
